// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: recovers symbol alignment from a bit-rotated
// 10-bit word stream by hunting for control tokens, then decodes each aligned
// symbol into a pixel byte or a 2-bit control code.
module tmds_decoder #(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_WINDOW   = 2048
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sym_in,
  output logic [7:0] dout,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset,
  output logic       slip
);

  localparam int MAX_A   = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
  localparam int MAX_WIN = (MAX_A > LOCK_COUNT) ? MAX_A : LOCK_COUNT;
  localparam int CW      = $clog2(MAX_WIN) + 1;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [9:0]    cur_reg;
  logic [9:0]    prev_reg;
  logic [19:0]   word_pair;
  logic [9:0]    win [10];
  logic [9:0]    s;
  logic          is_tok;
  logic [1:0]    tok_ctrl;
  logic [7:0]    d;
  logic [7:0]    data_byte;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] miss_cnt_reg, miss_cnt_next;
  logic [CW-1:0] tok_cnt_reg, tok_cnt_next;
  logic [CW-1:0] loss_cnt_reg, loss_cnt_next;
  logic [3:0]    offset_next;
  logic          slip_next;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Two-word history; the older word holds the earlier bits on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg  <= '0;
      prev_reg <= '0;
    end else begin
      cur_reg  <= sym_in;
      prev_reg <= cur_reg;
    end
  end

  assign word_pair = {cur_reg, prev_reg};

  // One candidate window per possible bit offset.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_win
      assign win[gi] = word_pair[gi +: 10];
    end
  endgenerate

  // Select the window at the current offset.
  always_comb begin
    s = win[0];
    for (int i = 1; i < 10; i++) begin
      if (offset == 4'(i)) s = win[i];
    end
  end

  // Control token recognition.
  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (s)
      10'h354: tok_ctrl = 2'b00;
      10'h0AB: tok_ctrl = 2'b01;
      10'h154: tok_ctrl = 2'b10;
      10'h2AB: tok_ctrl = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Data symbol decode: undo the optional inversion, then the XOR/XNOR chain.
  assign d            = s[9] ? ~s[7:0] : s[7:0];
  assign data_byte[0] = d[0];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_dec
      assign data_byte[gi] = s[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
    end
  endgenerate

  // Alignment FSM: hunt for a token, verify a run of tokens, then monitor for loss.
  always_comb begin
    state_next    = state_reg;
    miss_cnt_next = miss_cnt_reg;
    tok_cnt_next  = tok_cnt_reg;
    loss_cnt_next = loss_cnt_reg;
    offset_next   = offset;
    slip_next     = 1'b0;
    case (state_reg)
      ST_HUNT: begin
        if (is_tok) begin
          // A token wins over an expiring search window: no slip this cycle.
          state_next    = ST_VERIFY;
          tok_cnt_next  = CW'(1);
          miss_cnt_next = '0;
        end else if (miss_cnt_reg >= CW'(SEARCH_WINDOW - 1)) begin
          offset_next   = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          slip_next     = 1'b1;
          miss_cnt_next = '0;
        end else begin
          miss_cnt_next = sat_inc(miss_cnt_reg);
        end
      end
      ST_VERIFY: begin
        if (is_tok) begin
          tok_cnt_next = sat_inc(tok_cnt_reg);
          if (tok_cnt_reg >= CW'(LOCK_COUNT - 1)) begin
            state_next    = ST_LOCKED;
            loss_cnt_next = '0;
          end
        end else begin
          // A stray data symbol means this offset was a false match.
          state_next    = ST_HUNT;
          miss_cnt_next = '0;
          tok_cnt_next  = '0;
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          loss_cnt_next = '0;
        end else if (loss_cnt_reg >= CW'(LOSS_WINDOW - 1)) begin
          state_next    = ST_HUNT;
          miss_cnt_next = '0;
          tok_cnt_next  = '0;
          loss_cnt_next = '0;
        end else begin
          loss_cnt_next = sat_inc(loss_cnt_reg);
        end
      end
      default: begin
        state_next    = ST_HUNT;
        miss_cnt_next = '0;
        tok_cnt_next  = '0;
        loss_cnt_next = '0;
      end
    endcase
  end

  // FSM and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_HUNT;
      miss_cnt_reg <= '0;
      tok_cnt_reg  <= '0;
      loss_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      miss_cnt_reg <= miss_cnt_next;
      tok_cnt_reg  <= tok_cnt_next;
      loss_cnt_reg <= loss_cnt_next;
    end
  end

  // Registered outputs; de only qualifies data once the post-update state is locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      ctrl   <= '0;
      de     <= 1'b0;
      locked <= 1'b0;
      offset <= '0;
      slip   <= 1'b0;
    end else begin
      if (is_tok) begin
        ctrl <= tok_ctrl;
        de   <= 1'b0;
      end else begin
        dout <= data_byte;
        de   <= (state_next == ST_LOCKED);
      end
      locked <= (state_next == ST_LOCKED);
      offset <= offset_next;
      slip   <= slip_next;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock acquisition, data decode, bit-slip
// hunting, loss of lock, verify abort and asynchronous reset.
module tb_tmds_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sym_in = 10'h000;
  logic [7:0] dout;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;
  logic       slip;

  int checks = 0;
  int errors = 0;

  tmds_decoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sym_in (sym_in),
    .dout   (dout),
    .ctrl   (ctrl),
    .de     (de),
    .locked (locked),
    .offset (offset),
    .slip   (slip)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves reset released 1 ns after an edge; caller drives sym_in next.
  task automatic do_reset();
    rst_n  = 1'b0;
    sym_in = 10'h000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", ctrl); end
    checks++; if ({de, locked, slip} !== 3'b000) begin errors++; $display("FAIL reset_flags: got de/locked/slip=%b expected 000", {de, locked, slip}); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", offset); end
    $display("test_reset: outputs after reset dout=%h ctrl=%b de=%b locked=%b offset=%0d", dout, ctrl, de, locked, offset);
  endtask

  task automatic test_lock_offset0();
    do_reset();
    sym_in = 10'h354;
    ticks(9);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock0_early: got locked=%b expected 0 after 7 tokens", locked); end
    checks++; if (de !== 1'b0 || ctrl !== 2'b00) begin errors++; $display("FAIL lock0_tok: got de=%b ctrl=%b expected de=0 ctrl=00", de, ctrl); end
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock0_locked: got %b expected 1 after 8 tokens", locked); end
    checks++; if (offset !== 4'd0 || de !== 1'b0) begin errors++; $display("FAIL lock0_off: got offset=%0d de=%b expected 0/0", offset, de); end
    $display("test_lock_offset0: locked=%b offset=%0d ctrl=%b", locked, offset, ctrl);
  endtask

  task automatic test_data_decode();
    logic [9:0] syms [5];
    logic [7:0] exps [5];
    syms[0] = 10'h255; exps[0] = 8'h00;
    syms[1] = 10'h155; exps[1] = 8'hFF;
    syms[2] = 10'h2F0; exps[2] = 8'hEF;
    syms[3] = 10'h013; exps[3] = 8'hCB;
    syms[4] = 10'h1A5; exps[4] = 8'hEF;
    for (int i = 0; i < 5; i++) begin
      sym_in = syms[i];
      ticks(3);
      checks++;
      if (dout !== exps[i] || de !== 1'b1 || ctrl !== 2'b00) begin
        errors++;
        $display("FAIL data_%0d: sym=%h got dout=%h de=%b ctrl=%b expected dout=%h de=1 ctrl=00", i, syms[i], dout, de, ctrl, exps[i]);
      end
      $display("test_data_decode: sym=%h dout=%h de=%b", syms[i], dout, de);
    end
    sym_in = 10'h2AB;
    ticks(3);
    checks++;
    if (ctrl !== 2'b11 || de !== 1'b0 || dout !== 8'hEF) begin
      errors++;
      $display("FAIL tok_2ab: got ctrl=%b de=%b dout=%h expected ctrl=11 de=0 dout=ef", ctrl, de, dout);
    end
    $display("test_data_decode: token 2ab ctrl=%b de=%b dout=%h", ctrl, de, dout);
    sym_in = 10'h354;
    ticks(3);
    checks++; if (ctrl !== 2'b00 || locked !== 1'b1) begin errors++; $display("FAIL tok_354: got ctrl=%b locked=%b expected 00/1", ctrl, locked); end
  endtask

  task automatic test_loss();
    sym_in = 10'h255;
    ticks(2049);
    checks++; if (locked !== 1'b1 || de !== 1'b1) begin errors++; $display("FAIL loss_hold: got locked=%b de=%b expected 1/1 after 2047 data", locked, de); end
    tick();
    checks++; if (locked !== 1'b0 || de !== 1'b0) begin errors++; $display("FAIL loss_drop: got locked=%b de=%b expected 0/0 after 2048 data", locked, de); end
    $display("test_loss: after 2048 data locked=%b de=%b", locked, de);
    // Back in HUNT: a fresh run of 8 tokens is needed.
    sym_in = 10'h354;
    ticks(9);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_relock_early: got %b expected 0", locked); end
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_relock: got %b expected 1", locked); end
    sym_in = 10'h255;
    ticks(1999);
    sym_in = 10'h2AB;
    tick();
    sym_in = 10'h255;
    ticks(100);
    checks++;
    if (locked !== 1'b1 || ctrl !== 2'b11 || de !== 1'b1) begin
      errors++;
      $display("FAIL loss_refresh: got locked=%b ctrl=%b de=%b expected 1/11/1", locked, ctrl, de);
    end
    $display("test_loss: token at 2000 locked=%b ctrl=%b", locked, ctrl);
  endtask

  task automatic test_slip();
    int slip_edge [4];
    int slip_off [4];
    int nslip = 0;
    int lock_edge = 0;
    do_reset();
    sym_in = 10'h2A6;  // 0x354 tokens rotated so they align at offset 3
    for (int e = 1; e <= 7000; e++) begin
      tick();
      if (slip === 1'b1) begin
        if (nslip < 4) begin
          slip_edge[nslip] = e;
          slip_off[nslip]  = int'(offset);
        end
        nslip++;
        $display("test_slip: slip at edge %0d offset=%0d", e, offset);
      end
      if (locked === 1'b1) begin
        lock_edge = e;
        break;
      end
    end
    checks++; if (nslip != 3) begin errors++; $display("FAIL slip_count: got %0d expected 3", nslip); end
    for (int i = 0; i < 3; i++) begin
      if (i < nslip) begin
        checks++;
        if (slip_edge[i] != 2048 * (i + 1) || slip_off[i] != i + 1) begin
          errors++;
          $display("FAIL slip_%0d: got edge=%0d offset=%0d expected edge=%0d offset=%0d", i, slip_edge[i], slip_off[i], 2048 * (i + 1), i + 1);
        end
      end
    end
    checks++; if (lock_edge != 6152) begin errors++; $display("FAIL slip_lock: got lock edge %0d expected 6152", lock_edge); end
    checks++; if (offset !== 4'd3) begin errors++; $display("FAIL slip_offset: got %0d expected 3", offset); end
    $display("test_slip: locked=%b offset=%0d at edge %0d", locked, offset, lock_edge);
  endtask

  task automatic test_verify_abort();
    do_reset();
    sym_in = 10'h354;
    ticks(5);
    sym_in = 10'h255;
    tick();
    sym_in = 10'h354;
    ticks(9);
    checks++;
    if (locked !== 1'b0 || offset !== 4'd0 || slip !== 1'b0) begin
      errors++;
      $display("FAIL abort_hunt: got locked=%b offset=%0d slip=%b expected 0/0/0", locked, offset, slip);
    end
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort_relock: got %b expected 1 after 8 fresh tokens", locked); end
    $display("test_verify_abort: locked=%b offset=%0d", locked, offset);
  endtask

  task automatic test_async_reset();
    int nslip = 0;
    do_reset();
    sym_in = 10'h15D;  // 0x2AB tokens rotated so they align at offset 3
    for (int e = 1; e <= 7000 && nslip < 3; e++) begin
      tick();
      if (slip === 1'b1) nslip++;
    end
    ticks(4);
    checks++;
    if (ctrl !== 2'b11 || offset !== 4'd3 || locked !== 1'b0) begin
      errors++;
      $display("FAIL arst_pre: got ctrl=%b offset=%0d locked=%b expected 11/3/0", ctrl, offset, locked);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00 || ctrl !== 2'b00 || de !== 1'b0 || locked !== 1'b0 || offset !== 4'd0 || slip !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs: got dout=%h ctrl=%b de=%b locked=%b offset=%0d slip=%b expected all 0", dout, ctrl, de, locked, offset, slip);
    end
    $display("test_async_reset: during reset dout=%h ctrl=%b offset=%0d", dout, ctrl, offset);
    tick();
    rst_n  = 1'b1;
    sym_in = 10'h354;
    ticks(9);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_relock_early: got %b expected 0", locked); end
    tick();
    checks++; if (locked !== 1'b1 || offset !== 4'd0) begin errors++; $display("FAIL arst_relock: got locked=%b offset=%0d expected 1/0", locked, offset); end
    $display("test_async_reset: relocked=%b offset=%0d", locked, offset);
  endtask

  initial begin
    test_reset();
    test_lock_offset0();
    test_data_decode();
    test_loss();
    test_slip();
    test_verify_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
